// File: rtl/mlp_inference_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// mlp_inference_pipeline_pkg : shared widths and weight-slice helpers
// Rev 1.0
// ============================================================================
package mlp_inference_pipeline_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Result buses carry the valid flag one bit above the data.
  function automatic int valid_bit(input int dw);
    return dw;
  endfunction

  // LSB of neuron k's weight block inside a packed layer-weight vector.
  function automatic int weight_slice_lsb(input int neuron, input int amount, input int dw);
    return neuron * amount * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_inference_pipeline_relu_cell.sv
`default_nettype none
// ============================================================================
// relu_cell : converts a layer result train into an indexed, clamped stream
// Rev 1.0
// ============================================================================
module relu_cell
  import mlp_inference_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int WEIGHT_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   result_i,
  output logic [DATA_WIDTH-1:0] index_o,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  enable_o
);

  localparam int                    VB       = valid_bit(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d, index_d, value_d;

  always_comb begin
    cnt_d   = cnt_q;
    index_d = index_o;
    value_d = value_o;
    if (result_i[VB]) begin
      value_d = result_i[DATA_WIDTH-1] ? '0 : result_i[DATA_WIDTH-1:0];
      index_d = cnt_q;
      cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      index_o  <= '0;
      value_o  <= '0;
      enable_o <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      index_o  <= index_d;
      value_o  <= value_d;
      enable_o <= result_i[VB];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_inference_pipeline_softmax_cell.sv
`default_nettype none
// ============================================================================
// softmax_cell : running argmax over each output vector, lowest index on ties
// Rev 1.0
// ============================================================================
module softmax_cell
  import mlp_inference_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int WEIGHT_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] index_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  enable_i,
  output logic [DATA_WIDTH:0]   result_o
);

  localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] max_q, max_d, arg_q, arg_d;
  logic [DATA_WIDTH:0]   result_d;

  always_comb begin
    max_d    = max_q;
    arg_d    = arg_q;
    result_d = '0;
    if (enable_i) begin
      if ((index_i == '0) || ($signed(value_i) > $signed(max_q))) begin
        max_d = value_i;
        arg_d = index_i;
      end
      if (index_i == LAST_IDX) result_d = {1'b1, arg_d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q    <= '0;
      arg_q    <= '0;
      result_o <= '0;
    end else begin
      max_q    <= max_d;
      arg_q    <= arg_d;
      result_o <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_inference_pipeline_weight_comp_cell.sv
`default_nettype none
// ============================================================================
// weight_comp_cell : accumulating neuron stage of a systolic layer chain
// Rev 1.0
// ============================================================================
module weight_comp_cell
  import mlp_inference_pipeline_pkg::*;
#(
  parameter int                                  DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int                                  WEIGHT_AMOUNT = 4,
  parameter logic [WEIGHT_AMOUNT*DATA_WIDTH-1:0] WEIGHTS       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] index_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH:0]   result_i,
  output logic [DATA_WIDTH-1:0] index_o,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  enable_o,
  output logic [DATA_WIDTH:0]   result_o
);

  localparam int                    VB       = valid_bit(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(WEIGHT_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] weight, sum;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH:0]   result_d;

  always_comb begin
    weight = '0;
    for (int i = 0; i < WEIGHT_AMOUNT; i++) begin
      if (index_i == DATA_WIDTH'(i)) weight = WEIGHTS[i*DATA_WIDTH +: DATA_WIDTH];
    end
    // Low DATA_WIDTH bits of a product/sum are identical for signed and unsigned.
    sum        = ((index_i == '0) ? '0 : acc_q) + value_i * weight;
    acc_d      = enable_i ? sum : acc_q;
    result_d   = '0;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (result_i[VB]) begin
      result_d = result_i;
    end else if (pend_vld_q) begin
      result_d   = {1'b1, pend_q};
      pend_d     = '0;
      pend_vld_d = 1'b0;
    end
    // A completion landing on the emit cycle refills the slot.
    if (enable_i && (index_i == LAST_IDX)) begin
      pend_d     = sum;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      index_o    <= '0;
      value_o    <= '0;
      enable_o   <= 1'b0;
      result_o   <= '0;
    end else begin
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      index_o    <= index_i;
      value_o    <= value_i;
      enable_o   <= enable_i;
      result_o   <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlp_inference_pipeline.sv
`default_nettype none
// ============================================================================
// mlp_inference_pipeline : streaming two-layer perceptron with argmax output
// Rev 1.0
// ============================================================================
module mlp_inference_pipeline
  import mlp_inference_pipeline_pkg::*;
#(
  parameter int                                  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                                  N_IN       = 4,
  parameter int                                  N_HID      = 4,
  parameter int                                  N_OUT      = 4,
  parameter logic [N_HID*N_IN*DATA_WIDTH-1:0]    L1_WEIGHTS = '0,
  parameter logic [N_OUT*N_HID*DATA_WIDTH-1:0]   L2_WEIGHTS = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_index,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  in_enable,
  output logic [DATA_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_enable,
  output logic [DATA_WIDTH:0]   out_result
);

  logic [DATA_WIDTH-1:0] l1_idx [N_HID+1];
  logic [DATA_WIDTH-1:0] l1_val [N_HID+1];
  logic                  l1_en  [N_HID+1];
  logic [DATA_WIDTH:0]   l1_res [N_HID+1];
  logic [DATA_WIDTH-1:0] l2_idx [N_OUT+1];
  logic [DATA_WIDTH-1:0] l2_val [N_OUT+1];
  logic                  l2_en  [N_OUT+1];
  logic [DATA_WIDTH:0]   l2_res [N_OUT+1];

  assign l1_idx[0] = in_index;
  assign l1_val[0] = in_value;
  assign l1_en[0]  = in_enable;
  assign l1_res[0] = '0;
  assign l2_res[0] = '0;

  for (genvar k = 0; k < N_HID; k++) begin : g_l1
    weight_comp_cell #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_AMOUNT(N_IN),
      .WEIGHTS      (L1_WEIGHTS[weight_slice_lsb(k, N_IN, DATA_WIDTH) +: N_IN*DATA_WIDTH])
    ) u_cell (
      .clk(clk), .rst(rst),
      .index_i(l1_idx[k]),   .value_i(l1_val[k]),   .enable_i(l1_en[k]),   .result_i(l1_res[k]),
      .index_o(l1_idx[k+1]), .value_o(l1_val[k+1]), .enable_o(l1_en[k+1]), .result_o(l1_res[k+1])
    );
  end

  relu_cell #(.DATA_WIDTH(DATA_WIDTH), .WEIGHT_AMOUNT(N_HID)) u_relu_1 (
    .clk(clk), .rst(rst), .result_i(l1_res[N_HID]),
    .index_o(l2_idx[0]), .value_o(l2_val[0]), .enable_o(l2_en[0])
  );

  for (genvar k = 0; k < N_OUT; k++) begin : g_l2
    weight_comp_cell #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_AMOUNT(N_HID),
      .WEIGHTS      (L2_WEIGHTS[weight_slice_lsb(k, N_HID, DATA_WIDTH) +: N_HID*DATA_WIDTH])
    ) u_cell (
      .clk(clk), .rst(rst),
      .index_i(l2_idx[k]),   .value_i(l2_val[k]),   .enable_i(l2_en[k]),   .result_i(l2_res[k]),
      .index_o(l2_idx[k+1]), .value_o(l2_val[k+1]), .enable_o(l2_en[k+1]), .result_o(l2_res[k+1])
    );
  end

  relu_cell #(.DATA_WIDTH(DATA_WIDTH), .WEIGHT_AMOUNT(N_OUT)) u_relu_2 (
    .clk(clk), .rst(rst), .result_i(l2_res[N_OUT]),
    .index_o(out_index), .value_o(out_value), .enable_o(out_enable)
  );

  softmax_cell #(.DATA_WIDTH(DATA_WIDTH), .WEIGHT_AMOUNT(N_OUT)) u_softmax (
    .clk(clk), .rst(rst),
    .index_i(out_index), .value_i(out_value), .enable_i(out_enable),
    .result_o(out_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_mlp_inference_pipeline.sv
`default_nettype none
// ============================================================================
// tb_mlp_inference_pipeline : randomized bench with arithmetic reference model
// Rev 1.0
// ============================================================================
module tb_mlp_inference_pipeline;

  localparam int DW = 32;
  localparam logic [4*DW-1:0] N0 = {32'd1, 32'd2, 32'd3, 32'd4};
  localparam logic [4*DW-1:0] N1 = {32'd5, 32'd3, 32'd2, 32'd1};
  localparam logic [4*DW-1:0] N2 = {32'd1, 32'd1, 32'd1, 32'd1};
  localparam logic [4*DW-1:0] N3 = {32'd4, 32'd4, 32'd4, 32'd4};
  localparam logic [16*DW-1:0] WTS = {N3, N2, N1, N0};
  localparam logic [4*DW-1:0] CELL_W = {32'd4, 32'd3, 32'd2, 32'd1};

  // Weights as written, MSB first: weight i of neuron k is W[k][3-i].
  int W [4][4] = '{'{1, 2, 3, 4}, '{5, 3, 2, 1}, '{1, 1, 1, 1}, '{4, 4, 4, 4}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_index = '0, in_value = '0;
  logic          in_enable = 1'b0;
  logic [DW-1:0] out_index, out_value;
  logic          out_enable;
  logic [DW:0]   out_result;

  logic [DW-1:0] c_idx = '0, c_val = '0;
  logic          c_en = 1'b0;
  logic [DW:0]   c_res = '0;
  logic [DW-1:0] co_idx, co_val;
  logic          co_en;
  logic [DW:0]   co_res;

  always #5 clk = ~clk;

  mlp_inference_pipeline #(
    .DATA_WIDTH(DW), .N_IN(4), .N_HID(4), .N_OUT(4), .L1_WEIGHTS(WTS), .L2_WEIGHTS(WTS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_index(in_index), .in_value(in_value), .in_enable(in_enable),
    .out_index(out_index), .out_value(out_value), .out_enable(out_enable),
    .out_result(out_result)
  );

  weight_comp_cell #(.DATA_WIDTH(DW), .WEIGHT_AMOUNT(4), .WEIGHTS(CELL_W)) u_cell (
    .clk(clk), .rst(rst),
    .index_i(c_idx), .value_i(c_val), .enable_i(c_en), .result_i(c_res),
    .index_o(co_idx), .value_o(co_val), .enable_o(co_en), .result_o(co_res)
  );

  int errors = 0;
  int checks = 0;
  int exp_idx_q[$];
  int exp_val_q[$];
  int exp_arg_q[$];
  logic prev_last = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int x[4], output int y[4], output int am);
    int h[4];
    int s;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += W[k][3-i] * x[i];
      h[k] = (s < 0) ? 0 : s;
    end
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++) s += W[k][3-i] * h[i];
      y[k] = (s < 0) ? 0 : s;
    end
    am = 0;
    for (int k = 1; k < 4; k++) if (y[k] > y[am]) am = k;
  endfunction

  task automatic push_expect(input int y[4], input int am);
    for (int k = 0; k < 4; k++) begin
      exp_idx_q.push_back(k);
      exp_val_q.push_back(y[k]);
    end
    exp_arg_q.push_back(am);
  endtask

  task automatic send_vec(input int v[4]);
    for (int i = 0; i < 4; i++) begin
      in_index  = DW'(i);
      in_value  = v[i];
      in_enable = 1'b1;
      @(posedge clk); #1;
    end
    in_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_val_q.size() != 0 || exp_arg_q.size() != 0) && c < 200) begin
      @(posedge clk);
      c++;
    end
    check_eq("drain_timeout", 64'(exp_val_q.size() + exp_arg_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Output stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_last <= 1'b0;
    end else begin
      if (out_enable) begin
        if (exp_val_q.size() == 0) check_eq("spurious_out", 64'(out_enable), 0);
        else begin
          check_eq("out_index", 64'(out_index), 64'(exp_idx_q.pop_front()));
          check_eq("out_value", 64'(out_value), 64'(DW'(exp_val_q.pop_front())));
        end
      end
      if (out_result[DW]) begin
        check_eq("result_timing", 64'(prev_last), 1);
        if (exp_arg_q.size() == 0) check_eq("spurious_result", 64'(out_result[DW]), 0);
        else check_eq("out_result", 64'(out_result), 64'({1'b1, DW'(exp_arg_q.pop_front())}));
      end
      prev_last <= out_enable && (out_index == 3);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[4];
    int y[4];
    int am;
    int m;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_enable", 64'(out_enable), 0);
    check_eq("rst_out_index", 64'(out_index), 0);
    check_eq("rst_out_value", 64'(out_value), 0);
    check_eq("rst_out_result", 64'(out_result), 0);
    check_eq("rst_cell_result", 64'(co_res), 0);

    // Lone cell: upstream result arrives on the same cycle as the own completion.
    for (int i = 0; i < 4; i++) begin
      c_idx = DW'(i);
      c_val = 32'd1;
      c_en  = 1'b1;
      if (i == 3) c_res = {1'b1, 32'd777};
      @(posedge clk); #1;
      if (i < 3) check_eq("cell_idle_res", 64'(co_res), 0);
    end
    c_en  = 1'b0;
    c_res = '0;
    check_eq("cell_fwd_first", 64'(co_res), 64'({1'b1, 32'd777}));
    check_eq("cell_passthru_idx", 64'(co_idx), 3);
    @(posedge clk); #1;
    check_eq("cell_own_sum", 64'(co_res), 64'({1'b1, 32'd10}));
    @(posedge clk); #1;
    check_eq("cell_cleared", 64'(co_res), 0);

    // [1,1,1,1] then [2,2,2,2] back to back.
    y = '{97, 124, 41, 164};
    push_expect(y, 3);
    y = '{194, 248, 82, 328};
    push_expect(y, 3);
    v = '{1, 1, 1, 1};
    send_vec(v);
    v = '{2, 2, 2, 2};
    send_vec(v);
    drain();

    // All-negative input: hidden layer clamps to zero, tie resolves to index 0.
    y = '{0, 0, 0, 0};
    push_expect(y, 0);
    v = '{-1, -1, -1, -1};
    send_vec(v);
    drain();

    // Reset mid-vector, then a clean vector must give the scenario-1 results.
    for (int i = 0; i < 2; i++) begin
      in_index  = DW'(i);
      in_value  = 32'd7;
      in_enable = 1'b1;
      @(posedge clk); #1;
    end
    in_enable = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    y = '{97, 124, 41, 164};
    push_expect(y, 3);
    v = '{1, 1, 1, 1};
    send_vec(v);
    drain();

    // Randomized vectors with random gaps (0 = back to back).
    for (int n = 0; n < 30; n++) begin
      m = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++)
        v[i] = (m == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
      model(v, y, am);
      push_expect(y, am);
      send_vec(v);
      idle(int'($urandom_range(0, 3)));
    end
    drain();

    // Idle: nothing may come out.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_eq("idle_out_enable", 64'(out_enable), 0);
      check_eq("idle_result_valid", 64'(out_result[DW]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
